// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-requester single-port RAM arbiter.
// Requester indices select bits of the packed request/grant/tag vectors.
package ram_arb_pkg;

    localparam int DEF_ADR_WD = 8;
    localparam int DEF_DAT_WD = 32;

    localparam int NUM_REQ = 2;
    localparam int REQ_A   = 0;
    localparam int REQ_B   = 1;

    // 0 = A first, 1 = B first
    localparam logic PRIO_RST = 1'b0;

endpackage

// File: rtl/ram_arb_rd_hold.sv
// Per-requester read return path: passes RAM data through on the valid cycle
// and otherwise presents the last word returned to this requester.
module ram_arb_rd_hold #(
    parameter int DAT_WD = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tag,
    input  logic [DAT_WD-1:0] ram_rd_dat,
    output logic              rd_vld,
    output logic [DAT_WD-1:0] rd_dat
);

    logic [DAT_WD-1:0] hold_reg;

    // A read granted just before reset must not surface while reset is high.
    assign rd_vld = tag & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg <= '0;
        end else if (rd_vld) begin
            hold_reg <= ram_rd_dat;
        end
    end

    assign rd_dat = rst ? '0 : (rd_vld ? ram_rd_dat : hold_reg);

endmodule

// File: rtl/ram_sp_256x32_arb.sv
// Round-robin arbiter and sequencer letting two agents share one single-port
// 256x32 RAM: combinational grant, one access per cycle, tagged read return.
module ram_sp_256x32_arb
    import ram_arb_pkg::*;
#(
    parameter int ADR_WD = DEF_ADR_WD,
    parameter int DAT_WD = DEF_DAT_WD
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req_i,
    input  logic              a_wr_i,
    input  logic [ADR_WD-1:0] a_adr_i,
    input  logic [DAT_WD-1:0] a_dat_i,
    output logic              a_gnt_o,
    output logic              a_rd_vld_o,
    output logic [DAT_WD-1:0] a_rd_dat_o,

    input  logic              b_req_i,
    input  logic              b_wr_i,
    input  logic [ADR_WD-1:0] b_adr_i,
    input  logic [DAT_WD-1:0] b_dat_i,
    output logic              b_gnt_o,
    output logic              b_rd_vld_o,
    output logic [DAT_WD-1:0] b_rd_dat_o,

    output logic [ADR_WD-1:0] ram_adr_o,
    output logic              ram_wr_ena_o,
    output logic [DAT_WD-1:0] ram_wr_dat_o,
    output logic              ram_rd_ena_o,
    input  logic [DAT_WD-1:0] ram_rd_dat_i
);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] wr;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rd_gnt;
    logic [ADR_WD-1:0]  adr    [NUM_REQ];
    logic [DAT_WD-1:0]  wr_dat [NUM_REQ];
    logic [NUM_REQ-1:0] rd_vld;
    logic [DAT_WD-1:0]  rd_dat [NUM_REQ];

    logic               prio_reg;
    logic               prio_next;
    logic [NUM_REQ-1:0] rd_tag_reg;

    assign wr             = {b_wr_i, a_wr_i};
    assign adr[REQ_A]     = a_adr_i;
    assign adr[REQ_B]     = b_adr_i;
    assign wr_dat[REQ_A]  = a_dat_i;
    assign wr_dat[REQ_B]  = b_dat_i;

    // Requests are masked during reset so nothing reaches the RAM.
    always_comb begin
        req = {b_req_i, a_req_i} & {NUM_REQ{~rst}};
        gnt = '0;
        if (&req) begin
            gnt[prio_reg] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    assign rd_gnt  = gnt & ~wr;
    assign a_gnt_o = gnt[REQ_A];
    assign b_gnt_o = gnt[REQ_B];

    // After a grant the other requester goes first; idle cycles keep priority.
    assign prio_next = gnt[REQ_A] | (prio_reg & ~gnt[REQ_B]);

    always_comb begin
        ram_adr_o    = '0;
        ram_wr_dat_o = '0;
        ram_wr_ena_o = 1'b0;
        ram_rd_ena_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                ram_adr_o    = adr[i];
                ram_wr_dat_o = wr_dat[i];
                ram_wr_ena_o = wr[i];
                ram_rd_ena_o = ~wr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg   <= PRIO_RST;
            rd_tag_reg <= '0;
        end else begin
            prio_reg   <= prio_next;
            rd_tag_reg <= rd_gnt;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_hold
            ram_arb_rd_hold #(
                .DAT_WD(DAT_WD)
            ) u_hold (
                .clk        (clk),
                .rst        (rst),
                .tag        (rd_tag_reg[gi]),
                .ram_rd_dat (ram_rd_dat_i),
                .rd_vld     (rd_vld[gi]),
                .rd_dat     (rd_dat[gi])
            );
        end
    endgenerate

    assign a_rd_vld_o = rd_vld[REQ_A];
    assign b_rd_vld_o = rd_vld[REQ_B];
    assign a_rd_dat_o = rd_dat[REQ_A];
    assign b_rd_dat_o = rd_dat[REQ_B];

endmodule

// File: doc/ram_sp_256x32_arb.md
# ram_sp_256x32_arb

Two-requester round-robin arbiter and sequencer for one single-port 256x32 RAM (`ram_sp_256x32`). It lets two agents share the single port, for example a pipeline stage writing reconstructed pixels and a later stage reading them back. It issues at most one access per cycle and returns read data with fixed one-cycle RAM latency. Each requester also gets a held copy of its last read word.

## Interface
Parameters:
- `ADR_WD`, 8, RAM address width.
- `DAT_WD`, 32, RAM data width.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `a_req_i` input 1: requester A access request; held with its fields until `a_gnt_o`.
- `a_wr_i` input 1: 1 = write, 0 = read.
- `a_adr_i` input `ADR_WD`: access address.
- `a_dat_i` input `DAT_WD`: write data, ignored for reads.
- `a_gnt_o` output 1: combinational grant; the access is issued to the RAM this cycle.
- `a_rd_vld_o` output 1: read data valid, one cycle after a read grant.
- `a_rd_dat_o` output `DAT_WD`: read data; holds the last word returned to A.
- `b_req_i`, `b_wr_i`, `b_adr_i`, `b_dat_i`, `b_gnt_o`, `b_rd_vld_o`, `b_rd_dat_o`: identical set for requester B.
- `ram_adr_o` output `ADR_WD`: to RAM `adr_i`.
- `ram_wr_ena_o` output 1: to RAM `wr_ena_i`.
- `ram_wr_dat_o` output `DAT_WD`: to RAM `wr_dat_i`.
- `ram_rd_ena_o` output 1: to RAM `rd_ena_i`.
- `ram_rd_dat_i` input `DAT_WD`: from RAM `rd_dat_o`; valid the cycle after `rd_ena`.

## Operation
- Priority register `prio` (0 = A first, 1 = B first).
- Grant rules:
  - Only one requester asserts req: it is granted.
  - Both assert req: the requester named by `prio` is granted.
  - Neither asserts req: no grant.
- After any grant, `prio` points to the non-granted requester. With no grant, `prio` is unchanged.
- RAM drive, from the granted requester:
  - `ram_wr_ena_o = gnt & wr`.
  - `ram_rd_ena_o = gnt & ~wr`.
  - `ram_adr_o` and `ram_wr_dat_o` come from the granted requester.
- With no grant: both enables are 0, and `ram_adr_o` / `ram_wr_dat_o` are driven 0. `ram_wr_ena_o` and `ram_rd_ena_o` are never both 1.
- Read tag: register `rd_tag[1:0]`, one-hot {B,A}, loaded each cycle with the read-grant vector.
  - `x_rd_vld_o = rd_tag[x]`.
- Read data per requester:
  - When `x_rd_vld_o` = 1: `x_rd_dat_o = ram_rd_dat_i`, and `ram_rd_dat_i` is captured into hold register `x_hold`.
  - Otherwise: `x_rd_dat_o = x_hold`, stable until that requester's next read returns.
- No write/read forwarding: a write granted in cycle N followed by a read of the same address granted in N+1 returns the new data from the RAM itself.
- Fairness: a continuously requesting agent waits at most 1 cycle.

## Timing
- Grant latency is 0 cycles (combinational from req and `prio`). Each requester may issue back-to-back requests, one per cycle.
- Read latency: grant in cycle N gives `rd_vld` = 1 in cycle N+1, with data valid in N+1. `rd_vld` is a single-cycle pulse per read.
- Throughput: 1 access per cycle in aggregate.
- Reset values: `prio` = 0, `rd_tag` = 0, `a_hold` = `b_hold` = 0.
- Outputs during and after reset:
  - `a_rd_vld_o` = `b_rd_vld_o` = 0 and `a_rd_dat_o` = `b_rd_dat_o` = 0.
  - Grants remain combinational; requests are ignored while `rst` = 1 (gnt forced 0, RAM enables 0).
- Reset mid-operation: a read granted in the cycle before `rst` rises delivers no `rd_vld`; its data is discarded.

## Structure
- Shared package `ram_arb_pkg`:
  - default `ADR_WD`/`DAT_WD` constants.
  - requester index constants `REQ_A` = 0, `REQ_B` = 1.
  - `prio` reset value.
- Sub-module `ram_arb_rd_hold`: a vld-gated hold register plus output mux, instantiated once per requester.
- Top level contains the grant logic, `prio`, `rd_tag` and the RAM mux.

## Test plan
- Reset: `rst` high 3 cycles with both req=1 -> gnts 0, RAM enables 0, `rd_vld` 0, `rd_dat` 0, `prio` 0 after release.
- Single writer: A writes 0xDEADBEEF to 0x10, then reads 0x10 next cycle -> `ram_wr_ena_o` 1 at cycle 0. Cycle 1: `ram_rd_ena_o` 1. Cycle 2: `a_rd_vld_o` 1 with 0xDEADBEEF. `a_rd_dat_o` holds 0xDEADBEEF afterward.
- Contention: A and B both read continuously for 6 cycles -> grants alternate A,B,A,B,A,B. `rd_vld` pulses alternate one cycle later. Neither requester waits more than 1 cycle.
- Mixed: A writes 0x00000001 to 0xFF while B reads 0xFF in the same cycle, `prio` = A -> A granted first, B granted next cycle. B reads 0x00000001 (address wrap-edge 0xFF).
- Hold: B reads 0x20 (=0x55AA), then idles 10 cycles while A reads 0x21 -> `b_rd_dat_o` stays 0x55AA throughout. `b_rd_vld_o` pulses only once.
- Reset mid-read: A read granted at cycle N, `rst` = 1 at N+1 -> no `a_rd_vld_o`, `a_rd_dat_o` = 0.
